lift_seq_ctrl: RTL and testbench

//  Sequencer directly upstream of the add_mul_ram lifting arithmetic stage.

---
 rtl/lift_seq_ctrl_if.sv | 46 ++++
 rtl/lift_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lift_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_seq_ctrl_if.sv
// lift_seq_ctrl_if
//   Bundles the sample-RAM port pair and the arithmetic-stage operand/result
//   signals used by the lifting sequencer.
//   master: the sequencer (drives addresses, strobes, operands)
//   slave : RAMs + arithmetic stage (return read data and result)
// Signals
//   pix_addr_even/odd  AW  RAM addresses (read and write)
//   pix_dout_even/odd  W   RAM read data, valid one cycle after address
//   pix_we_even/odd    1   RAM write strobes
//   wr_data            W   RAM write data (shared by both RAMs)
//   pix_left/right/p   W   operands to the arithmetic stage
//   pix_even_odd       1   1 = predict (odd target), 0 = update (even target)
//   pix_fwd_inv        1   captured transform direction
//   op_valid           1   operands stable this cycle
//   res_din            W   combinational result from the arithmetic stage
interface lift_seq_ctrl_if #(
  parameter int W  = 26,
  parameter int AW = 7
);
  logic [AW-1:0] pix_addr_even;
  logic [AW-1:0] pix_addr_odd;
  logic [W-1:0]  pix_dout_even;
  logic [W-1:0]  pix_dout_odd;
  logic          pix_we_even;
  logic          pix_we_odd;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  pix_left;
  logic [W-1:0]  pix_right;
  logic [W-1:0]  pix_p;
  logic          pix_even_odd;
  logic          pix_fwd_inv;
  logic          op_valid;
  logic [W-1:0]  res_din;

  modport master (
    output pix_addr_even, pix_addr_odd, pix_we_even, pix_we_odd, wr_data,
           pix_left, pix_right, pix_p, pix_even_odd, pix_fwd_inv, op_valid,
    input  pix_dout_even, pix_dout_odd, res_din
  );

  modport slave (
    input  pix_addr_even, pix_addr_odd, pix_we_even, pix_we_odd, wr_data,
           pix_left, pix_right, pix_p, pix_even_odd, pix_fwd_inv, op_valid,
    output pix_dout_even, pix_dout_odd, res_din
  );
endinterface

// File: rtl/lift_seq_ctrl.sv
// lift_seq_ctrl
//   Sequencer feeding the 5/3 lifting arithmetic stage. Walks one row held in
//   split even/odd RAMs, fetching left/right/centre operands per sample and
//   writing the returned result back in place. Two passes per start:
//   forward = predict then update, inverse = update then predict.
//   Every sample takes RD0, RD1, RD2, EX, WR (5 cycles).
// Optional feature
//   LIFT_CYC_CNT_EN : adds o_cyc_cnt, a saturating count of busy cycles,
//                     cleared on start and held after done.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_start    in   begin a row (honoured only while idle)
//   i_fwd_inv  in   1 = forward, 0 = inverse; captured with start
//   o_busy     out  high while a row is in progress
//   o_done     out  one-cycle pulse after the final write
//   o_cyc_cnt  out  busy-cycle counter (LIFT_CYC_CNT_EN only)
//   bus        if   RAM and arithmetic-stage signals (master side)
module lift_seq_ctrl #(
  parameter int W     = 26,
  parameter int AW    = 7,
  parameter int NHALF = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_fwd_inv,
  output logic o_busy,
  output logic o_done,
`ifdef LIFT_CYC_CNT_EN
  output logic [15:0] o_cyc_cnt,
`endif
  lift_seq_ctrl_if.master bus
);

  localparam int IW       = AW + 1;
  localparam int LAST_INT = NHALF - 1;
  localparam logic [AW:0] LAST_IDX = LAST_INT[AW:0];

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_EX, S_WR, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW:0]   r_idx;
  logic          r_pass;
  logic          r_fwdInv;
  logic [W-1:0]  r_left;
  logic [W-1:0]  r_right;
  logic [W-1:0]  r_p;
  logic [W-1:0]  r_wrData;

  logic          w_predict;
  logic          w_active;
  logic          w_lastIdx;
  logic [AW-1:0] w_idxAddr;
  logic [AW-1:0] w_idxUp;
  logic [AW-1:0] w_idxDn;
  logic [AW-1:0] w_addrEven;
  logic [AW-1:0] w_addrOdd;
  logic          w_weEven;
  logic          w_weOdd;

  // First pass matches the direction (forward starts with predict); the
  // second pass flips it.
  assign w_predict = r_fwdInv ^ r_pass;
  assign w_active  = (r_state == S_RD0) || (r_state == S_RD1) || (r_state == S_RD2) ||
                     (r_state == S_EX)  || (r_state == S_WR);
  assign w_lastIdx = (r_idx == LAST_IDX);
  assign w_idxAddr = r_idx[AW-1:0];
  // Symmetric extension: the right neighbour of the last sample and the left
  // neighbour of sample 0 mirror back onto the edge sample.
  assign w_idxUp   = w_lastIdx ? w_idxAddr : w_idxAddr + AW'(1);
  assign w_idxDn   = (r_idx == '0) ? w_idxAddr : w_idxAddr - AW'(1);

  // State register; reset drops any row in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: fixed five-state walk per sample, pass turnover and row end
  // decided at WR.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_nextState = S_RD0;
      S_RD0:   w_nextState = S_RD1;
      S_RD1:   w_nextState = S_RD2;
      S_RD2:   w_nextState = S_EX;
      S_EX:    w_nextState = S_WR;
      S_WR:    w_nextState = (w_lastIdx && r_pass) ? S_DONE : S_RD0;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // RAM addressing and write strobes. Both addresses sit on the current
  // index while active; RD0 (update) and RD1 (predict) point one RAM at the
  // neighbour sample instead.
  always_comb begin
    w_addrEven = '0;
    w_addrOdd  = '0;
    w_weEven   = 1'b0;
    w_weOdd    = 1'b0;
    if (w_active) begin
      w_addrEven = w_idxAddr;
      w_addrOdd  = w_idxAddr;
    end
    case (r_state)
      S_RD0: if (!w_predict) w_addrOdd  = w_idxDn;
      S_RD1: if (w_predict)  w_addrEven = w_idxUp;
      S_WR: begin
        w_weOdd  = w_predict;
        w_weEven = !w_predict;
      end
      default: ;
    endcase
  end

  // Control and operand registers. Read data arrives one cycle after its
  // address, so RD1 captures the RD0 fetch and RD2 captures the RD1 fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_pass   <= 1'b0;
      r_fwdInv <= 1'b0;
      r_left   <= '0;
      r_right  <= '0;
      r_p      <= '0;
      r_wrData <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_fwdInv <= i_fwd_inv;
          r_idx    <= '0;
          r_pass   <= 1'b0;
        end
        S_RD1: begin
          r_left <= w_predict ? bus.pix_dout_even : bus.pix_dout_odd;
          r_p    <= w_predict ? bus.pix_dout_odd  : bus.pix_dout_even;
        end
        S_RD2: r_right  <= w_predict ? bus.pix_dout_even : bus.pix_dout_odd;
        S_EX:  r_wrData <= bus.res_din;
        S_WR: begin
          if (!w_lastIdx) begin
            r_idx <= r_idx + IW'(1);
          end else if (!r_pass) begin
            r_idx  <= '0;
            r_pass <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LIFT_CYC_CNT_EN
  logic [15:0] r_cycCnt;

  // Busy-cycle counter: restarts with each row, saturates, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_cycCnt <= '0;
    else if (r_state == S_IDLE && i_start)  r_cycCnt <= '0;
    else if (w_active && r_cycCnt != 16'hFFFF) r_cycCnt <= r_cycCnt + 16'd1;
  end

  assign o_cyc_cnt = r_cycCnt;
`endif

  assign o_busy            = w_active;
  assign o_done            = (r_state == S_DONE);
  assign bus.pix_addr_even = w_addrEven;
  assign bus.pix_addr_odd  = w_addrOdd;
  assign bus.pix_we_even   = w_weEven;
  assign bus.pix_we_odd    = w_weOdd;
  assign bus.wr_data       = r_wrData;
  assign bus.pix_left      = r_left;
  assign bus.pix_right     = r_right;
  assign bus.pix_p         = r_p;
  assign bus.pix_even_odd  = w_active & w_predict;
  assign bus.pix_fwd_inv   = r_fwdInv;
  assign bus.op_valid      = (r_state == S_EX);

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// tb_lift_seq_ctrl
//   Drives lift_seq_ctrl (NHALF=4) against behavioural even/odd RAMs and a
//   stub arithmetic stage (res = p + 2*left + right). Rows come from a vector
//   table with hand-derived final RAM contents; a lifting model fills
//   operand/write queues when each row starts, and a monitor pops them as the
//   DUT presents operands and write strobes.
`timescale 1ns/1ps
module tb_lift_seq_ctrl;
  localparam int W  = 26;
  localparam int AW = 3;
  localparam int NH = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic start  = 1'b0;
  logic fwdInv = 1'b0;
  logic busy;
  logic done;
`ifdef LIFT_CYC_CNT_EN
  logic [15:0] cycCnt;
`endif

  lift_seq_ctrl_if #(.W(W), .AW(AW)) bus ();

  lift_seq_ctrl #(.W(W), .AW(AW), .NHALF(NH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .i_fwd_inv (fwdInv),
    .o_busy    (busy),
    .o_done    (done),
`ifdef LIFT_CYC_CNT_EN
    .o_cyc_cnt (cycCnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Sample RAMs: registered read, write on the same edge.
  logic [W-1:0] memEven [0:(1<<AW)-1];
  logic [W-1:0] memOdd  [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.pix_we_even) memEven[bus.pix_addr_even] <= bus.wr_data;
    if (bus.pix_we_odd)  memOdd[bus.pix_addr_odd]   <= bus.wr_data;
    bus.pix_dout_even <= memEven[bus.pix_addr_even];
    bus.pix_dout_odd  <= memOdd[bus.pix_addr_odd];
  end

  assign bus.res_din = bus.pix_p + (bus.pix_left << 1) + bus.pix_right;

  typedef struct packed {
    logic             fwd;
    logic             midStart;
    logic [3:0][15:0] evenIn;
    logic [3:0][15:0] oddIn;
    logic [3:0][15:0] evenExp;
    logic [3:0][15:0] oddExp;
  } vecT;

  typedef struct packed {
    logic         eo;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic [W-1:0] p;
  } opT;

  typedef struct packed {
    logic          isOdd;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wrT;

  vecT vecs [3];
  opT  opQ [$];
  wrT  wrQ [$];
  opT  expOp;
  wrT  expWr;
  int  total = 0;
  int  bad = 0;
  int  busyCnt = 0;
  logic curFwd = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] pack4(input int a, input int b, input int c, input int d);
    logic [3:0][15:0] r;
    r[0] = a[15:0];
    r[1] = b[15:0];
    r[2] = c[15:0];
    r[3] = d[15:0];
    return r;
  endfunction

  task automatic loadMems(input vecT v);
    for (int k = 0; k < (1 << AW); k++) begin
      memEven[k] = '0;
      memOdd[k]  = '0;
    end
    for (int k = 0; k < NH; k++) begin
      memEven[k] = W'($signed(v.evenIn[k]));
      memOdd[k]  = W'($signed(v.oddIn[k]));
    end
  endtask

  // Reference lifting walk with symmetric extension; fills the expectations.
  task automatic buildModel(input vecT v);
    longint e [NH];
    longint o [NH];
    longint l, r, p, res;
    logic   pred;
    int     ip, im;
    for (int k = 0; k < NH; k++) begin
      e[k] = longint'($signed(v.evenIn[k]));
      o[k] = longint'($signed(v.oddIn[k]));
    end
    for (int pass = 0; pass < 2; pass++) begin
      pred = (pass == 0) ? v.fwd : !v.fwd;
      for (int i = 0; i < NH; i++) begin
        ip = (i == NH - 1) ? i : i + 1;
        im = (i == 0) ? 0 : i - 1;
        if (pred) begin
          l = e[i]; r = e[ip]; p = o[i];
        end else begin
          l = o[im]; r = o[i]; p = e[i];
        end
        res = p + 2 * l + r;
        if (pred) o[i] = res;
        else      e[i] = res;
        opQ.push_back('{eo: pred, left: W'(l), right: W'(r), p: W'(p)});
        wrQ.push_back('{isOdd: pred, addr: AW'(i), data: W'(res)});
      end
    end
  endtask

  task automatic applyStimulus(input logic fwd);
    @(posedge clk);
    #1;
    fwdInv  = fwd;
    curFwd  = fwd;
    start   = 1'b1;
    busyCnt = 0;
    @(posedge clk);
    #1;
    start  = 1'b0;
    fwdInv = !fwd;
  endtask

  task automatic waitDone(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done_timeout", done, 1);
  endtask

  // Busy-cycle tally for the current row.
  always @(negedge clk) begin
    if (busy) busyCnt++;
  end

  // Scoreboard monitor: operands at op_valid, target/address/data at each write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.op_valid) begin
        if (opQ.size() == 0) begin
          checkOutput("unexpected_op", bus.op_valid, 0);
        end else begin
          expOp = opQ.pop_front();
          checkOutput("op_left",  longint'($signed(bus.pix_left)),  longint'($signed(expOp.left)));
          checkOutput("op_right", longint'($signed(bus.pix_right)), longint'($signed(expOp.right)));
          checkOutput("op_p",     longint'($signed(bus.pix_p)),     longint'($signed(expOp.p)));
          checkOutput("op_even_odd", bus.pix_even_odd, expOp.eo);
          checkOutput("op_fwd_inv",  bus.pix_fwd_inv, curFwd);
        end
      end
      if (bus.pix_we_even || bus.pix_we_odd) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_we", bus.pix_we_even | bus.pix_we_odd, 0);
        end else begin
          expWr = wrQ.pop_front();
          checkOutput("we_one_hot", bus.pix_we_even & bus.pix_we_odd, 0);
          checkOutput("we_odd_target", bus.pix_we_odd, expWr.isOdd);
          checkOutput("we_addr", expWr.isOdd ? bus.pix_addr_odd : bus.pix_addr_even, expWr.addr);
          checkOutput("we_data", longint'($signed(bus.wr_data)), longint'($signed(expWr.data)));
        end
      end
    end
  end

  initial begin
    bit seen;
    int nOps;

    vecs[0].fwd = 1'b1; vecs[0].midStart = 1'b0;
    vecs[0].evenIn  = pack4(10, 20, 30, 40);
    vecs[0].oddIn   = pack4(5, 6, 7, 8);
    vecs[0].evenExp = pack4(145, 186, 289, 382);
    vecs[0].oddExp  = pack4(45, 76, 107, 128);

    vecs[1].fwd = 1'b0; vecs[1].midStart = 1'b0;
    vecs[1].evenIn  = pack4(10, 20, 30, 40);
    vecs[1].oddIn   = pack4(5, 6, 7, 8);
    vecs[1].evenExp = pack4(25, 36, 49, 62);
    vecs[1].oddExp  = pack4(91, 127, 167, 194);

    vecs[2].fwd = 1'b1; vecs[2].midStart = 1'b1;
    vecs[2].evenIn  = pack4(-3, 0, 7, -1);
    vecs[2].oddIn   = pack4(2, -4, 1, 0);
    vecs[2].evenExp = pack4(-15, -5, 27, 24);
    vecs[2].oddExp  = pack4(-4, 3, 14, -3);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_op_valid", bus.op_valid, 0);
    checkOutput("rst_we", bus.pix_we_even | bus.pix_we_odd, 0);
    checkOutput("rst_addr", bus.pix_addr_even | bus.pix_addr_odd, 0);
    checkOutput("rst_ops", bus.pix_left | bus.pix_right | bus.pix_p | bus.wr_data, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Table rows
    for (int r = 0; r < 3; r++) begin
      loadMems(vecs[r]);
      buildModel(vecs[r]);
      applyStimulus(vecs[r].fwd);
      if (vecs[r].midStart) begin
        repeat (7) @(posedge clk);
        #1;
        start  = 1'b1;
        fwdInv = !vecs[r].fwd;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
      end
      waitDone(seen);
      if (seen) begin
        checkOutput($sformatf("row%0d_busy_cycles", r), busyCnt, 10 * NH);
        checkOutput($sformatf("row%0d_busy_at_done", r), busy, 0);
`ifdef LIFT_CYC_CNT_EN
        checkOutput($sformatf("row%0d_cyc_cnt", r), cycCnt, 10 * NH);
`endif
        @(negedge clk);
        checkOutput($sformatf("row%0d_done_width", r), done, 0);
      end
      checkOutput($sformatf("row%0d_opq_left", r), opQ.size(), 0);
      checkOutput($sformatf("row%0d_wrq_left", r), wrQ.size(), 0);
      for (int k = 0; k < NH; k++) begin
        checkOutput($sformatf("row%0d_even%0d", r, k),
                    longint'($signed(memEven[k])), longint'($signed(vecs[r].evenExp[k])));
        checkOutput($sformatf("row%0d_odd%0d", r, k),
                    longint'($signed(memOdd[k])), longint'($signed(vecs[r].oddExp[k])));
      end
      opQ.delete();
      wrQ.delete();
    end

    // Abort: reset during EX of predict sample i=2
    loadMems(vecs[0]);
    buildModel(vecs[0]);
    applyStimulus(1'b1);
    nOps = 0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.op_valid) begin
        nOps++;
        if (nOps == 3) begin
          seen = 1'b1;
          break;
        end
      end
    end
    if (!seen) checkOutput("abort_reach_ex", bus.op_valid, 1);
    #1 rst_n = 1'b0;
    opQ.delete();
    wrQ.delete();
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_op_valid", bus.op_valid, 0);
    checkOutput("abort_we", bus.pix_we_even | bus.pix_we_odd, 0);
    checkOutput("abort_addr", bus.pix_addr_even | bus.pix_addr_odd, 0);
    checkOutput("abort_left", bus.pix_left, 0);
    checkOutput("abort_p", bus.pix_p, 0);
    checkOutput("abort_wr_data", bus.wr_data, 0);
    checkOutput("abort_fwd_inv", bus.pix_fwd_inv, 0);
    checkOutput("abort_even_odd", bus.pix_even_odd, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_odd1", longint'($signed(memOdd[1])), 76);
    checkOutput("abort_odd2", longint'($signed(memOdd[2])), 7);
    checkOutput("abort_even0", longint'($signed(memEven[0])), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
